// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port valid/ready arbiter for the single-port unified memory
module mem_port_arbiter #(
  parameter bit          FAIR           = 1'b1,
  parameter logic [31:0] RDATA_ON_WRITE = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req_addr0,
  input  logic [31:0] req_addr1,
  input  logic [1:0]  req_wen,
  input  logic [31:0] req_wdata0,
  input  logic [31:0] req_wdata1,
  input  logic [2:0]  req_func3_0,
  input  logic [2:0]  req_func3_1,
  output logic [1:0]  rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_func3,
  input  logic [31:0] mem_rd
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic [31:0] hold_addr_q, hold_addr_d;
  logic [31:0] hold_wdata_q, hold_wdata_d;
  logic [2:0]  hold_func3_q, hold_func3_d;
  logic        hold_wen_q, hold_wen_d;
  logic        hold_owner_q, hold_owner_d;
  logic [1:0]  grant;
  logic        accept;

  // Grant is only offered to a valid port, so any grant bit is an accept.
  always_comb begin
    grant = 2'b00;
    if (!reset && state_q != ISSUE) begin
      case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = (FAIR && !last_grant_q) ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  assign req_ready = grant;
  assign accept    = |grant;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    hold_addr_d  = hold_addr_q;
    hold_wdata_d = hold_wdata_q;
    hold_func3_d = hold_func3_q;
    hold_wen_d   = hold_wen_q;
    hold_owner_d = hold_owner_q;

    case (state_q)
      IDLE:    state_d = accept ? ISSUE : IDLE;
      ISSUE:   state_d = RESP;
      RESP:    state_d = accept ? ISSUE : IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      last_grant_d = grant[1];
      hold_owner_d = grant[1];
      hold_addr_d  = grant[1] ? req_addr1   : req_addr0;
      hold_wdata_d = grant[1] ? req_wdata1  : req_wdata0;
      hold_func3_d = grant[1] ? req_func3_1 : req_func3_0;
      hold_wen_d   = grant[1] ? req_wen[1]  : req_wen[0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      hold_addr_q  <= 32'h0;
      hold_wdata_q <= 32'h0;
      hold_func3_q <= 3'b000;
      hold_wen_q   <= 1'b0;
      hold_owner_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      hold_addr_q  <= hold_addr_d;
      hold_wdata_q <= hold_wdata_d;
      hold_func3_q <= hold_func3_d;
      hold_wen_q   <= hold_wen_d;
      hold_owner_q <= hold_owner_d;
    end
  end

  // Holding registers only change on accept, so the address naturally holds outside ISSUE.
  assign mem_addr  = hold_addr_q;
  assign mem_wdata = hold_wdata_q;
  assign mem_wen   = (state_q == ISSUE) && hold_wen_q;
  assign mem_func3 = (state_q == ISSUE) ? hold_func3_q : 3'b010;

  assign rsp_valid = (state_q != RESP) ? 2'b00 : (hold_owner_q ? 2'b10 : 2'b01);
  assign rsp_rdata = (state_q != RESP) ? 32'h0 : (hold_wen_q ? RDATA_ON_WRITE : mem_rd);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter, round-robin and fixed-priority instances
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [1:0]  req_valid, req_wen;
  logic [31:0] req_addr0, req_addr1, req_wdata0, req_wdata1;
  logic [2:0]  req_func3_0, req_func3_1;

  logic [1:0]  ready_a, rsp_valid_a, ready_b, rsp_valid_b;
  logic [31:0] rsp_rdata_a, mem_addr_a, mem_wdata_a, mem_rd_a;
  logic [31:0] rsp_rdata_b, mem_addr_b, mem_wdata_b, mem_rd_b;
  logic        mem_wen_a, mem_wen_b;
  logic [2:0]  mem_func3_a, mem_func3_b;

  mem_port_arbiter #(.FAIR(1'b1), .RDATA_ON_WRITE(32'h0)) dut_a (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready_a),
    .req_addr0(req_addr0), .req_addr1(req_addr1), .req_wen(req_wen),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .req_func3_0(req_func3_0), .req_func3_1(req_func3_1),
    .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a), .mem_addr(mem_addr_a),
    .mem_wen(mem_wen_a), .mem_wdata(mem_wdata_a), .mem_func3(mem_func3_a), .mem_rd(mem_rd_a)
  );

  mem_port_arbiter #(.FAIR(1'b0), .RDATA_ON_WRITE(32'h0)) dut_b (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready_b),
    .req_addr0(req_addr0), .req_addr1(req_addr1), .req_wen(req_wen),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .req_func3_0(req_func3_0), .req_func3_1(req_func3_1),
    .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b), .mem_addr(mem_addr_b),
    .mem_wen(mem_wen_b), .mem_wdata(mem_wdata_b), .mem_func3(mem_func3_b), .mem_rd(mem_rd_b)
  );

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEADBEEF : {a[15:0], 16'hC0DE};
  endfunction

  always @(posedge clk) begin
    mem_rd_a <= mem_f(mem_addr_a);
    mem_rd_b <= mem_f(mem_addr_b);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  v;
    logic [31:0] d;
    int          due;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b;
  bit   chk_a = 1'b0, chk_b = 1'b0;
  int   n_cmp = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_accept(input bit on_b, input int port, input logic [31:0] d);
    logic [1:0] oh;
    oh = (port == 0) ? 2'b01 : 2'b10;
    if (!on_b) begin
      chk("grant_a", {30'b0, ready_a}, {30'b0, oh});
      q_a.push_back('{oh, d, cyc + 2});
    end else begin
      chk("grant_b", {30'b0, ready_b}, {30'b0, oh});
      q_b.push_back('{oh, d, cyc + 2});
    end
  endtask

  always @(negedge clk) begin
    if (chk_a) begin
      if (rsp_valid_a != 2'b00) begin
        n_cmp++;
        if (q_a.size() == 0) begin
          n_fail++;
          $display("FAIL rsp_a_unexpected: got valid %b data %h expected no response", rsp_valid_a, rsp_rdata_a);
        end else begin
          e_a = q_a.pop_front();
          if (rsp_valid_a !== e_a.v || rsp_rdata_a !== e_a.d || cyc != e_a.due) begin
            n_fail++;
            $display("FAIL rsp_a: got valid %b data %h cycle %0d expected valid %b data %h cycle %0d",
                     rsp_valid_a, rsp_rdata_a, cyc, e_a.v, e_a.d, e_a.due);
          end
        end
      end else if (q_a.size() > 0 && q_a[0].due <= cyc) begin
        e_a = q_a.pop_front();
        n_cmp++;
        n_fail++;
        $display("FAIL rsp_a_missing: got no response at cycle %0d expected valid %b data %h", cyc, e_a.v, e_a.d);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_b) begin
      if (rsp_valid_b != 2'b00) begin
        n_cmp++;
        if (q_b.size() == 0) begin
          n_fail++;
          $display("FAIL rsp_b_unexpected: got valid %b data %h expected no response", rsp_valid_b, rsp_rdata_b);
        end else begin
          e_b = q_b.pop_front();
          if (rsp_valid_b !== e_b.v || rsp_rdata_b !== e_b.d || cyc != e_b.due) begin
            n_fail++;
            $display("FAIL rsp_b: got valid %b data %h cycle %0d expected valid %b data %h cycle %0d",
                     rsp_valid_b, rsp_rdata_b, cyc, e_b.v, e_b.d, e_b.due);
          end
        end
      end else if (q_b.size() > 0 && q_b[0].due <= cyc) begin
        e_b = q_b.pop_front();
        n_cmp++;
        n_fail++;
        $display("FAIL rsp_b_missing: got no response at cycle %0d expected valid %b data %h", cyc, e_b.v, e_b.d);
      end
    end
  end

  initial begin
    reset = 1'b1; req_valid = 2'b11; req_wen = 2'b00;
    req_addr0 = 32'h0; req_addr1 = 32'h0; req_wdata0 = 32'h0; req_wdata1 = 32'h0;
    req_func3_0 = 3'b010; req_func3_1 = 3'b010;

    // reset state
    @(negedge clk); @(negedge clk); #1;
    chk("rst_ready_a", {30'b0, ready_a}, 32'h0);
    chk("rst_ready_b", {30'b0, ready_b}, 32'h0);
    chk("rst_mem_addr", mem_addr_a, 32'h0);
    chk("rst_mem_wen", {31'b0, mem_wen_a}, 32'h0);
    chk("rst_mem_wdata", mem_wdata_a, 32'h0);
    chk("rst_mem_func3", {29'b0, mem_func3_a}, 32'h2);
    chk("rst_rsp_valid", {30'b0, rsp_valid_a}, 32'h0);
    chk("rst_rsp_rdata", rsp_rdata_a, 32'h0);
    @(negedge clk); reset = 1'b0; req_valid = 2'b00; chk_a = 1'b1;

    // single load on port 0
    @(negedge clk); req_valid = 2'b01; req_addr0 = 32'h10; req_func3_0 = 3'b010; #1;
    expect_accept(1'b0, 0, 32'hDEADBEEF);
    @(negedge clk); req_valid = 2'b00; #1;
    chk("load_mem_addr", mem_addr_a, 32'h10);
    chk("load_mem_wen", {31'b0, mem_wen_a}, 32'h0);
    chk("load_mem_func3", {29'b0, mem_func3_a}, 32'h2);
    @(negedge clk); @(negedge clk);

    // store on port 1
    @(negedge clk); req_valid = 2'b10; req_wen = 2'b10; req_addr1 = 32'h20;
    req_wdata1 = 32'h12345678; req_func3_1 = 3'b000; #1;
    expect_accept(1'b0, 1, 32'h0);
    @(negedge clk); req_valid = 2'b00; #1;
    chk("store_mem_wen", {31'b0, mem_wen_a}, 32'h1);
    chk("store_mem_addr", mem_addr_a, 32'h20);
    chk("store_mem_wdata", mem_wdata_a, 32'h12345678);
    chk("store_mem_func3", {29'b0, mem_func3_a}, 32'h0);
    @(negedge clk); #1;
    chk("store_wen_one_cycle", {31'b0, mem_wen_a}, 32'h0);
    chk("resp_mem_func3", {29'b0, mem_func3_a}, 32'h2);
    @(negedge clk); req_wen = 2'b00; req_func3_1 = 3'b010;

    // round-robin after reset: both ports valid for 8 cycles
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); req_valid = 2'b11; req_addr0 = 32'h100; req_addr1 = 32'h200; #1;
      if (i % 2 == 0)
        expect_accept(1'b0, (i % 4 == 0) ? 0 : 1, (i % 4 == 0) ? 32'h0100C0DE : 32'h0200C0DE);
      else
        chk("rr_no_ready_in_issue", {30'b0, ready_a}, 32'h0);
    end
    @(negedge clk); req_valid = 2'b00;
    @(negedge clk);

    // reset while a store is in ISSUE
    @(negedge clk); req_valid = 2'b10; req_wen = 2'b10; req_addr1 = 32'h40; req_wdata1 = 32'hCAFEF00D; #1;
    chk("rst_issue_grant", {30'b0, ready_a}, 32'h2);
    @(negedge clk); req_valid = 2'b00; #1;
    chk("rst_issue_wen_before", {31'b0, mem_wen_a}, 32'h1);
    reset = 1'b1; req_valid = 2'b11; req_wen = 2'b00;
    @(negedge clk); #1;
    chk("rst_issue_wen_after", {31'b0, mem_wen_a}, 32'h0);
    chk("rst_issue_no_rsp", {30'b0, rsp_valid_a}, 32'h0);
    chk("rst_high_ready", {30'b0, ready_a}, 32'h0);
    reset = 1'b0; #1;
    expect_accept(1'b0, 0, 32'h0100C0DE);
    @(negedge clk); req_valid = 2'b00; #1;
    chk("post_rst_load_wen", {31'b0, mem_wen_a}, 32'h0);
    @(negedge clk); @(negedge clk);

    // back-to-back loads on port 0
    @(negedge clk); req_valid = 2'b01; req_addr0 = 32'h0; #1;
    expect_accept(1'b0, 0, 32'h0000C0DE);
    @(negedge clk); req_addr0 = 32'h4; #1;
    chk("b2b_addr0", mem_addr_a, 32'h0);
    @(negedge clk); #1;
    expect_accept(1'b0, 0, 32'h0004C0DE);
    @(negedge clk); req_addr0 = 32'h8; #1;
    chk("b2b_addr4", mem_addr_a, 32'h4);
    @(negedge clk); #1;
    expect_accept(1'b0, 0, 32'h0008C0DE);
    @(negedge clk); req_valid = 2'b00; #1;
    chk("b2b_addr8", mem_addr_a, 32'h8);
    @(negedge clk); @(negedge clk);
    chk_a = 1'b0;

    // fixed priority instance
    reset = 1'b1;
    @(negedge clk); reset = 1'b0; chk_b = 1'b1;
    @(negedge clk); req_valid = 2'b11; req_addr0 = 32'h0; req_addr1 = 32'h300; #1;
    expect_accept(1'b1, 0, 32'h0000C0DE);
    @(negedge clk); #1;
    chk("fp_issue_ready", {30'b0, ready_b}, 32'h0);
    @(negedge clk); #1;
    expect_accept(1'b1, 0, 32'h0000C0DE);
    @(negedge clk); #1;
    chk("fp_issue_ready2", {30'b0, ready_b}, 32'h0);
    @(negedge clk); req_valid = 2'b10; #1;
    expect_accept(1'b1, 1, 32'h0300C0DE);
    @(negedge clk); req_valid = 2'b00;
    @(negedge clk); @(negedge clk); #1;

    chk("sb_a_drained", q_a.size(), 32'h0);
    chk("sb_b_drained", q_b.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
